stream_mux_rr: RTL
==================

Name: stream_mux_rr

Overview:
Parametrised N-to-1 stream multiplexer with a registered output. It is the next generation of the team's 2:1 data mux. Each input channel carries valid/ready/last handshakes. The output channel is chosen either by an external select (manual mode) or by round-robin arbitration. A grant is held for a whole packet, from the first beat up to and including the beat with last=1. The block sits in front of shared datapath resources such as the register-file write port and the memory request bus.

Parameters:
N, 4, number of input channels (2..16)
WIDTH, 32, data width per channel
SELW, $clog2(N), select/source-index width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = manual (use sel), 1 = round-robin
sel  input  SELW  manual channel select
in_valid  input  N  per-channel beat valid
in_data  input  N*WIDTH  flattened; channel i occupies bits [i*WIDTH +: WIDTH]
in_last  input  N  per-channel end-of-packet
in_ready  output  N  per-channel beat accepted this cycle
out_valid  output  1  output beat valid
out_data  output  WIDTH  output beat data
out_last  output  1  output end-of-packet
out_src  output  SELW  index of the channel that produced the output beat
out_ready  input  1  downstream accepts the output beat

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_last=0, out_src=0.
  - RR pointer ptr=0, locked=0, lock_ch=0.
  - in_ready is forced to all-zero while rst_n is low.
- Output register:
  - load_en = !out_valid || out_ready.
  - The register loads when load_en and the granted channel is valid. This is a single stage, so latency is 1 cycle and throughput is 1 beat/cycle.
  - If load_en is high and no channel is granted, out_valid clears on the next edge.
  - While out_valid=1 and out_ready=0, out_data, out_last and out_src hold stable.
- Grant selection (combinational):
  - If locked: grant = lock_ch; mode and sel are ignored.
  - Else if mode=0: grant = sel if sel<N and in_valid[sel]=1; otherwise no grant.
  - Else (mode=1): grant = first i with in_valid[i]=1, searching ptr, ptr+1, ... mod N. If no channel is valid, there is no grant.
- in_ready[i] = rst_n && load_en && (grant==i) && a grant exists.
  - At most one in_ready bit is high per cycle.
  - in_ready may depend on in_valid; in_valid must not depend on in_ready.
- Beat transfer: in_valid[i] && in_ready[i].
- Lock state:
  - A transfer with in_last=0 sets locked=1 and lock_ch=i.
  - A transfer with in_last=1 clears locked.
  - A single-beat packet (last=1 on the first beat) never sets the lock.
- RR pointer: on a transfer with in_last=1 from channel g, ptr <= (g+1) mod N. This includes wrap from N-1 to 0. The pointer updates in both modes.
- Locked channel goes idle mid-packet (in_valid drops): the lock holds, no other channel is granted, and out_valid drains.
- Reset mid-packet: the lock is discarded immediately. The partial packet is not completed; upstream is responsible for recovery.
- Simultaneous events: output drain (out_ready) and a new load happen in the same cycle without a bubble.

Decomposition:
- Package stream_mux_pkg: mode_e enum (MODE_MANUAL=1'b0, MODE_RR=1'b1) and the constant MAX_N=16.
- Sub-module rr_arbiter (N, ptr, req -> gnt_idx, gnt_vld): a pure combinational rotating priority search. stream_mux_rr holds ptr, the lock state and the output register.

Test Plan:
1. Reset: rst_n=0 with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0. After release with mode=1, the first output beat has out_src=0.
2. Manual mode: mode=0, sel=2, in_data[2]=32'hA5A5_0002, in_last[2]=1, out_ready=1 -> in_ready=0100. One cycle later: out_valid=1, out_data=32'hA5A5_0002, out_src=2.
3. Round-robin, all four channels valid with single-beat packets, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles, with no bubbles.
4. Packet lock: channel 1 sends 3 beats (last on the third) while channel 2 stays valid and sel changes to 2 mid-packet -> channel 1's three beats are output consecutively, then ptr=2 and channel 2 is granted.
5. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data and out_src stable, in_ready=0000. When out_ready returns to 1, the next beat follows in the same cycle without a gap.
6. Manual mode with N=3 and sel=3 (out of range) -> no grant, in_ready=000, out_valid falls to 0 once the pending beat is accepted.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared types and limits for the round-robin stream mux
//
// Purpose: channel-selection mode encoding and the supported channel-count ceiling.
// Ports:   none (package).
package stream_mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  localparam int MAX_N = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority request search
//
// Purpose: finds the first asserted request starting at ptr and wrapping modulo N.
// Ports:
//   ptr      in   SELW  index with highest priority this cycle (must be < N)
//   req      in   N     per-channel request
//   gnt_idx  out  SELW  winning channel index (0 when none)
//   gnt_vld  out  1     a request was found
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [SELW-1:0] ptr,
  input  logic [N-1:0]    req,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return SELW'(s);
  endfunction

  // Walk from the lowest priority to the highest so the last hit (closest
  // to ptr) is the one that sticks.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr, k)]) begin
        gnt_idx = wrap_add(ptr, k);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-to-1 packet-locked stream mux with registered output
//
// Purpose: selects one input channel per packet (manual select or round-robin)
// and forwards its beats through a single output register stage.
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   mode       in   1        0 = manual (sel), 1 = round-robin
//   sel        in   SELW     manual channel select
//   in_valid   in   N        per-channel beat valid
//   in_data    in   N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_last    in   N        per-channel end-of-packet
//   in_ready   out  N        per-channel beat accepted this cycle
//   out_valid  out  1        output beat valid
//   out_data   out  WIDTH    output beat data
//   out_last   out  1        output end-of-packet
//   out_src    out  SELW     channel that produced the output beat
//   out_ready  in   1        downstream accepts the output beat
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [SELW-1:0]    out_src,
  input  logic               out_ready
);

  localparam int PADN = 1 << SELW;

  logic [SELW-1:0]  ptr;
  logic             locked;
  logic [SELW-1:0]  lock_ch;

  logic [PADN-1:0]  valid_pad;
  logic [PADN-1:0]  last_pad;
  logic [SELW-1:0]  rr_idx;
  logic             rr_vld;
  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic             grant_last;
  logic [WIDTH-1:0] grant_data;
  logic             load_en;
  logic             xfer;

  // Pad valid/last to the full select range so an out-of-range manual
  // select simply reads a zero instead of indexing past the vector.
  always_comb begin
    valid_pad          = '0;
    last_pad           = '0;
    valid_pad[N-1:0]   = in_valid;
    last_pad[N-1:0]    = in_last;
  end

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .ptr     (ptr),
    .req     (in_valid),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  assign load_en = !out_valid || out_ready;

  // A held lock keeps its grant even when the channel stalls mid-packet,
  // so no other channel can interleave beats into the open packet.
  always_comb begin
    grant     = lock_ch;
    grant_vld = 1'b1;
    if (!locked) begin
      if (mode_e'(mode) == MODE_MANUAL) begin
        grant     = sel;
        grant_vld = valid_pad[sel];
      end else begin
        grant     = rr_idx;
        grant_vld = rr_vld;
      end
    end
  end

  assign xfer       = load_en && grant_vld && valid_pad[grant];
  assign grant_last = last_pad[grant];

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (rst_n && load_en && grant_vld && grant == SELW'(i)) in_ready[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
      ptr       <= '0;
      locked    <= 1'b0;
      lock_ch   <= '0;
    end else begin
      if (load_en) begin
        out_valid <= xfer;
        if (xfer) begin
          out_data <= grant_data;
          out_last <= grant_last;
          out_src  <= grant;
        end
      end
      if (xfer) begin
        if (grant_last) begin
          locked <= 1'b0;
          ptr    <= (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
        end else begin
          locked  <= 1'b1;
          lock_ch <= grant;
        end
      end
    end
  end

endmodule
